imm_gen: RTL and testbench
==========================

IMM_GEN -- requirements
Module: imm_gen

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the immediate output width (legal range 8..32).
REQ-002 The block SHALL have parameter PREFIX_MAX, default 2, giving the maximum number of buffered prefix words (legal range 1..4).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port instr_valid, input, 1 bit: instr and sel are valid this cycle.
REQ-006 The block SHALL have port instr, input, 8 bits: instruction byte.
REQ-007 The block SHALL have port sel, input, 3 bits: field-select mode.
REQ-008 The block SHALL have port stall, input, 1 bit: freezes all state and outputs.
REQ-009 The block SHALL have port flush, input, 1 bit: discards pending prefix and output.
REQ-010 The block SHALL have port imm, output, DATA_W bits: registered immediate.
REQ-011 The block SHALL have port imm_valid, output, 1 bit: imm carries a new value.
REQ-012 The block SHALL have port prefix_pending, output, 1 bit: prefix count is nonzero.
REQ-013 The block SHALL have port prefix_ovf, output, 1 bit: one-cycle pulse when a prefix is dropped.

Function
REQ-014 Field modes SHALL be as follows, with field width fw in brackets:
- 0: zero-extend instr[4:2] [3]
- 1: zero-extend instr[3:0] [4]
- 2: sign-extend instr[4:0] [5]
- 3: constant zero
- 4: PREFIX
- 5: sign-extend instr[5:0] [6]
- 6: zero-extend instr[5:0] [6]
- 7: constant zero (reserved)
REQ-015 An accepted instruction SHALL be one with instr_valid=1, stall=0 and flush=0.
REQ-016 An accepted PREFIX with count<PREFIX_MAX SHALL update acc <= (acc<<6)|instr[5:0] (truncated to DATA_W), increment the count, and leave imm/imm_valid unchanged except that imm_valid goes to 0.
REQ-017 An accepted PREFIX with count==PREFIX_MAX SHALL leave acc and count unchanged and assert prefix_ovf for exactly the next cycle.
REQ-018 An accepted non-PREFIX instruction in modes 0,1,2,5,6 SHALL register imm = ((acc<<fw)|field) truncated to DATA_W, with imm_valid=1 on the next cycle, giving 1-cycle latency.
REQ-019 In sign modes (2,5), the concatenated value SHALL be sign-extended from bit L-1, where L = 6*count+fw; if L>=DATA_W, truncation alone SHALL apply.
REQ-020 Modes 3 and 7 SHALL register imm=0 with imm_valid=1, ignoring any pending prefix.
REQ-021 Any accepted non-PREFIX instruction SHALL clear acc and count in the same edge.
REQ-022 A cycle with no accepted instruction and stall=0 SHALL drive imm_valid=0 and hold imm.
REQ-023 stall=1 SHALL hold acc, count, imm, imm_valid and prefix_ovf; prefix_ovf SHALL then resume its pulse after stall.
REQ-024 flush=1 SHALL take priority over stall and instr_valid: clear acc, count, imm_valid and prefix_ovf; imm is held.
REQ-025 prefix_pending SHALL equal (count!=0), registered.

Reset
REQ-026 With rst_n=0 at a clock edge, the block SHALL set imm=0, imm_valid=0, prefix_ovf=0, prefix_pending=0, acc=0 and count=0, taking priority over all other inputs.
REQ-027 Reset asserted mid prefix sequence SHALL discard the sequence; the first instruction after release SHALL decode as unprefixed.

Structure
REQ-028 Package imm_pkg SHALL hold the sel mode encodings, the field-width constants and PREFIX_W=6.
REQ-029 Sub-module imm_field_decode SHALL be combinational: instr and sel in, raw field, fw and sign flag out; imm_gen holds all state.

Verification
REQ-030 With DATA_W=16: sel=2, instr=0x1F -> imm=0xFFFF next cycle; sel=0, instr=0x1C -> imm=0x0007.
REQ-031 With DATA_W=16: PREFIX instr=0x2A, then sel=1 instr=0x05 -> imm=0x02A5, imm_valid pulse only after the second instruction, prefix_pending=1 between the two.
REQ-032 With DATA_W=16: PREFIX 0x3F, then sel=2 instr=0x10 -> imm=0xFFF0.
REQ-033 With PREFIX_MAX=2: three PREFIX instructions -> prefix_ovf pulses once after the third, and the following sel=6 value reflects only the first two prefixes.
REQ-034 stall held for 3 cycles across an output -> imm/imm_valid are frozen; flush during pending prefix -> prefix_pending=0 next cycle, and the next sel=1 instr=0x05 -> imm=0x0005.
REQ-035 rst_n=0 mid prefix sequence -> all outputs 0 next edge; after release, sel=1 instr=0x03 -> imm=0x0003.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared encodings for the immediate generator: field-select modes,
// field widths and the prefix chunk width.
package imm_pkg;

    localparam int PREFIX_W = 6;

    typedef enum logic [2:0] {
        SEL_ZX3    = 3'd0,
        SEL_ZX4    = 3'd1,
        SEL_SX5    = 3'd2,
        SEL_ZERO   = 3'd3,
        SEL_PREFIX = 3'd4,
        SEL_SX6    = 3'd5,
        SEL_ZX6    = 3'd6,
        SEL_RSVD   = 3'd7
    } sel_e;

    localparam logic [2:0] FW_NONE = 3'd0;
    localparam logic [2:0] FW_ZX3  = 3'd3;
    localparam logic [2:0] FW_ZX4  = 3'd4;
    localparam logic [2:0] FW_SX5  = 3'd5;
    localparam logic [2:0] FW_6    = 3'd6;

    // Modes that produce a constant zero and discard any pending prefix.
    function automatic logic is_const_zero(input sel_e sel);
        return (sel == SEL_ZERO) || (sel == SEL_RSVD);
    endfunction

endpackage

// File: rtl/imm_field_decode.sv
// Combinational field extractor: picks the raw immediate field, its width
// and whether it is signed, from the instruction byte and select mode.
module imm_field_decode
    import imm_pkg::*;
(
    input  logic [7:0] instr,
    input  logic [2:0] sel,
    output logic [5:0] field,
    output logic [2:0] fw,
    output logic       sgn
);

    sel_e sel_s;
    assign sel_s = sel_e'(sel);

    // Field select; prefix and constant modes contribute no field bits.
    always_comb begin
        field = 6'd0;
        fw    = FW_NONE;
        sgn   = 1'b0;
        case (sel_s)
            SEL_ZX3: begin
                field = {3'd0, instr[4:2]};
                fw    = FW_ZX3;
            end
            SEL_ZX4: begin
                field = {2'd0, instr[3:0]};
                fw    = FW_ZX4;
            end
            SEL_SX5: begin
                field = {1'b0, instr[4:0]};
                fw    = FW_SX5;
                sgn   = 1'b1;
            end
            SEL_SX6: begin
                field = instr[5:0];
                fw    = FW_6;
                sgn   = 1'b1;
            end
            SEL_ZX6: begin
                field = instr[5:0];
                fw    = FW_6;
            end
            default: begin
                field = 6'd0;
                fw    = FW_NONE;
                sgn   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen.sv
// Immediate generator: accumulates up to PREFIX_MAX 6-bit prefix words and
// concatenates them with the decoded field into a registered immediate.
module imm_gen
    import imm_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PREFIX_MAX = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [7:0]        instr,
    input  logic [2:0]        sel,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] imm,
    output logic              imm_valid,
    output logic              prefix_pending,
    output logic              prefix_ovf
);

    localparam logic [2:0] CNT_MAX = 3'(PREFIX_MAX);
    localparam logic [5:0] DW6     = 6'(DATA_W);

    logic [DATA_W-1:0] acc_r, acc_s;
    logic [2:0]        cnt_r, cnt_s;
    logic [DATA_W-1:0] imm_r, imm_s;
    logic              vld_r, vld_s;
    logic              ovf_r, ovf_s;
    logic              pend_r;

    logic [5:0]        field_s;
    logic [2:0]        fw_s;
    logic              sgn_s;
    sel_e              sel_s;
    logic              accept_s;
    logic [5:0]        len_s;
    logic [DATA_W-1:0] cat_s;
    logic [DATA_W-1:0] shifted_s;
    logic [DATA_W-1:0] ext_s;

    imm_field_decode u_decode (
        .instr (instr),
        .sel   (sel),
        .field (field_s),
        .fw    (fw_s),
        .sgn   (sgn_s)
    );

    assign sel_s    = sel_e'(sel);
    assign accept_s = instr_valid & ~stall & ~flush;

    // Concatenate prefix bits with the field; sign-extend from the top
    // concatenated bit only when that bit lies inside the output word.
    always_comb begin
        len_s     = 6'(cnt_r) * 6'(PREFIX_W) + 6'(fw_s);
        cat_s     = (acc_r << fw_s) | DATA_W'(field_s);
        shifted_s = cat_s >> (len_s - 6'd1);
        if (sgn_s && (len_s < DW6) && shifted_s[0]) begin
            ext_s = cat_s | ({DATA_W{1'b1}} << len_s);
        end else begin
            ext_s = cat_s;
        end
    end

    // Next-state selection: flush beats stall, stall freezes everything.
    always_comb begin
        acc_s = acc_r;
        cnt_s = cnt_r;
        imm_s = imm_r;
        vld_s = vld_r;
        ovf_s = ovf_r;
        if (flush) begin
            acc_s = '0;
            cnt_s = 3'd0;
            vld_s = 1'b0;
            ovf_s = 1'b0;
        end else if (stall) begin
            acc_s = acc_r;
            cnt_s = cnt_r;
            vld_s = vld_r;
            ovf_s = ovf_r;
        end else if (accept_s) begin
            if (sel_s == SEL_PREFIX) begin
                vld_s = 1'b0;
                if (cnt_r < CNT_MAX) begin
                    acc_s = (acc_r << PREFIX_W) | DATA_W'(instr[5:0]);
                    cnt_s = cnt_r + 3'd1;
                    ovf_s = 1'b0;
                end else begin
                    ovf_s = 1'b1;
                end
            end else begin
                imm_s = is_const_zero(sel_s) ? '0 : ext_s;
                vld_s = 1'b1;
                acc_s = '0;
                cnt_s = 3'd0;
                ovf_s = 1'b0;
            end
        end else begin
            vld_s = 1'b0;
            ovf_s = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r  <= '0;
            cnt_r  <= 3'd0;
            imm_r  <= '0;
            vld_r  <= 1'b0;
            ovf_r  <= 1'b0;
            pend_r <= 1'b0;
        end else begin
            acc_r  <= acc_s;
            cnt_r  <= cnt_s;
            imm_r  <= imm_s;
            vld_r  <= vld_s;
            ovf_r  <= ovf_s;
            pend_r <= (cnt_s != 3'd0);
        end
    end

    assign imm            = imm_r;
    assign imm_valid      = vld_r;
    assign prefix_pending = pend_r;
    assign prefix_ovf     = ovf_r;

endmodule

// File: tb/tb_imm_gen.sv
// Directed bench for imm_gen (DATA_W=16, PREFIX_MAX=2) with hand-computed
// expected immediates and flag values.
module tb_imm_gen;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [7:0]  instr;
    logic [2:0]  sel;
    logic        stall;
    logic        flush;
    logic [15:0] imm;
    logic        imm_valid;
    logic        prefix_pending;
    logic        prefix_ovf;

    int tests_run;
    int tests_failed;

    imm_gen #(.DATA_W(16), .PREFIX_MAX(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .sel            (sel),
        .stall          (stall),
        .flush          (flush),
        .imm            (imm),
        .imm_valid      (imm_valid),
        .prefix_pending (prefix_pending),
        .prefix_ovf     (prefix_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic v, input logic [7:0] i, input logic [2:0] s,
                        input logic st, input logic fl);
        instr_valid = v;
        instr       = i;
        sel         = s;
        stall       = st;
        flush       = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [15:0] e_imm, input logic e_vld,
                           input logic e_pend, input logic e_ovf);
        chk({tag, ".imm"},  {16'd0, imm},             {16'd0, e_imm});
        chk({tag, ".vld"},  {31'd0, imm_valid},       {31'd0, e_vld});
        chk({tag, ".pend"}, {31'd0, prefix_pending},  {31'd0, e_pend});
        chk({tag, ".ovf"},  {31'd0, prefix_ovf},      {31'd0, e_ovf});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        instr_valid  = 1'b0;
        instr        = 8'h00;
        sel          = 3'd0;
        stall        = 1'b0;
        flush        = 1'b0;

        step(1'b1, 8'hFF, 3'd1, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 3'd1, 1'b0, 1'b0);
        chk_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        step(1'b1, 8'h1F, 3'd2, 1'b0, 1'b0);
        chk_out("sx5_neg", 16'hFFFF, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        chk_out("idle", 16'hFFFF, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h1C, 3'd0, 1'b0, 1'b0);
        chk_out("zx3", 16'h0007, 1'b1, 1'b0, 1'b0);

        step(1'b1, 8'h2A, 3'd4, 1'b0, 1'b0);
        chk_out("pfx1", 16'h0007, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h05, 3'd1, 1'b0, 1'b0);
        chk_out("pfx_zx4", 16'h02A5, 1'b1, 1'b0, 1'b0);

        step(1'b1, 8'h3F, 3'd4, 1'b0, 1'b0);
        step(1'b1, 8'h10, 3'd2, 1'b0, 1'b0);
        chk_out("pfx_sx5", 16'hFFF0, 1'b1, 1'b0, 1'b0);

        // Overflow: third prefix dropped, pulse frozen by stall.
        step(1'b1, 8'h01, 3'd4, 1'b0, 1'b0);
        step(1'b1, 8'h02, 3'd4, 1'b0, 1'b0);
        chk_out("ovf_pre", 16'hFFF0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h03, 3'd4, 1'b0, 1'b0);
        chk_out("ovf", 16'hFFF0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'h03, 3'd4, 1'b1, 1'b0);
        chk_out("ovf_stall", 16'hFFF0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        chk_out("ovf_end", 16'hFFF0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h3F, 3'd6, 1'b0, 1'b0);
        chk_out("ovf_zx6", 16'h10BF, 1'b1, 1'b0, 1'b0);

        step(1'b1, 8'h09, 3'd1, 1'b0, 1'b0);
        chk_out("pre_stall", 16'h0009, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 8'hFF, 3'd3, 1'b1, 1'b0);
            chk_out("stall", 16'h0009, 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        chk_out("post_stall", 16'h0009, 1'b0, 1'b0, 1'b0);

        step(1'b1, 8'h15, 3'd4, 1'b0, 1'b0);
        chk_out("fl_pfx", 16'h0009, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h15, 3'd4, 1'b1, 1'b1);
        chk_out("flush", 16'h0009, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h05, 3'd1, 1'b0, 1'b0);
        chk_out("post_flush", 16'h0005, 1'b1, 1'b0, 1'b0);

        step(1'b1, 8'h1F, 3'd5, 1'b0, 1'b0);
        chk_out("sx6_pos", 16'h001F, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h20, 3'd5, 1'b0, 1'b0);
        chk_out("sx6_neg", 16'hFFE0, 1'b1, 1'b0, 1'b0);

        step(1'b1, 8'h3F, 3'd4, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 3'd3, 1'b0, 1'b0);
        chk_out("zero_mode", 16'h0000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h0A, 3'd1, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 3'd7, 1'b0, 1'b0);
        chk_out("rsvd_mode", 16'h0000, 1'b1, 1'b0, 1'b0);

        // Concatenated length 18 exceeds 16: truncation only.
        step(1'b1, 8'h01, 3'd4, 1'b0, 1'b0);
        step(1'b1, 8'h3F, 3'd4, 1'b0, 1'b0);
        step(1'b1, 8'h3F, 3'd5, 1'b0, 1'b0);
        chk_out("long_sx", 16'h1FFF, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h2A, 3'd4, 1'b0, 1'b0);
        chk_out("invalid", 16'h1FFF, 1'b0, 1'b0, 1'b0);

        step(1'b1, 8'h2A, 3'd4, 1'b0, 1'b0);
        chk_out("rst_pfx", 16'h1FFF, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        step(1'b1, 8'h2A, 3'd4, 1'b0, 1'b0);
        chk_out("rst_mid", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b1, 8'h03, 3'd1, 1'b0, 1'b0);
        chk_out("post_rst", 16'h0003, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
